// File: rtl/demux_stream.sv
// demux_stream: 1-to-2 valid/ready stream demultiplexer.
// Each accepted input beat is steered by in_s into one of two independent
// FIFOs (in_s=1 -> x, in_s=0 -> y), so a stalled consumer on one side never
// blocks traffic to the other side while that side's FIFO has room.
//
// Parameters:
//   n     - payload width in bits (>= 1)
//   DEPTH - entries per output FIFO (power of two, >= 2)
//   CW    - occupancy counter width, derived as $clog2(DEPTH)+1
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_data/in_s        - input beat payload and route select
//   in_valid/in_ready   - input handshake
//   x_data/x_valid      - head of x FIFO (data forced to 0 when empty)
//   x_ready             - x consumer pop
//   y_data/y_valid      - head of y FIFO (data forced to 0 when empty)
//   y_ready             - y consumer pop
//   x_count/y_count     - FIFO occupancy, 0..DEPTH
//
// Optional feature (macro DEMUX_STATS_EN):
//   x_beats/y_beats     - 16-bit saturating counts of completed pops
module demux_stream #(
    parameter int n     = 4,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [n-1:0]  in_data,
    input  logic          in_s,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [n-1:0]  x_data,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [n-1:0]  y_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [CW-1:0] x_count,
    output logic [CW-1:0] y_count
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]   x_beats,
    output logic [15:0]   y_beats
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [n-1:0]  x_mem [DEPTH];
    logic [n-1:0]  y_mem [DEPTH];
    logic [PW-1:0] x_wr, x_rd, y_wr, y_rd;

    logic x_push, x_pop, y_push, y_pop;

    // Readiness looks only at the registered count of the selected FIFO, so a
    // full FIFO refuses a push even when it is being popped this cycle. This
    // keeps the consumer ready signals out of the producer's timing path.
    always_comb begin
        in_ready = in_s ? (x_count != FULL) : (y_count != FULL);
        x_valid  = (x_count != '0);
        y_valid  = (y_count != '0);
        x_data   = x_valid ? x_mem[x_rd] : '0;
        y_data   = y_valid ? y_mem[y_rd] : '0;
        x_push   = in_valid && in_ready && in_s;
        y_push   = in_valid && in_ready && !in_s;
        x_pop    = x_valid && x_ready;
        y_pop    = y_valid && y_ready;
    end

    // Storage is intentionally left unreset; valid gating hides stale entries.
    always_ff @(posedge clk) begin
        if (x_push) x_mem[x_wr] <= in_data;
        if (y_push) y_mem[y_wr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_wr    <= '0;
            x_rd    <= '0;
            y_wr    <= '0;
            y_rd    <= '0;
            x_count <= '0;
            y_count <= '0;
        end else begin
            if (x_push) x_wr <= x_wr + PW'(1);
            if (x_pop)  x_rd <= x_rd + PW'(1);
            if (y_push) y_wr <= y_wr + PW'(1);
            if (y_pop)  y_rd <= y_rd + PW'(1);
            x_count <= x_count + CW'(x_push) - CW'(x_pop);
            y_count <= y_count + CW'(y_push) - CW'(y_pop);
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_beats <= '0;
            y_beats <= '0;
        end else begin
            if (x_pop && (x_beats != '1)) x_beats <= x_beats + 16'd1;
            if (y_pop && (y_beats != '1)) y_beats <= y_beats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream (n=4, DEPTH=2).
// A reference model tracks per-output occupancy and data queues; expected
// beats are queued on accept and compared when the matching output pops.
module tb_demux_stream;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_data;
    logic          in_s;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x_data, y_data;
    logic          x_valid, y_valid;
    logic          x_ready, y_ready;
    logic [CW-1:0] x_count, y_count;
`ifdef DEMUX_STATS_EN
    logic [15:0]   x_beats, y_beats;
`endif

    demux_stream #(.n(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_s     (in_s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .x_count  (x_count),
        .y_count  (y_count)
`ifdef DEMUX_STATS_EN
        ,
        .x_beats  (x_beats),
        .y_beats  (y_beats)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [N-1:0] xq[$];
    logic [N-1:0] yq[$];
    int mx = 0, my = 0;
    int xb = 0, yb = 0;

    // Inputs change 1 time unit after posedge; the monitor samples at negedge
    // and predicts what the next posedge will do.
    always @(negedge clk) begin
        bit xpush, ypush, xpop, ypop;
        if (!rst_n) begin
            xq.delete();
            yq.delete();
            mx = 0; my = 0; xb = 0; yb = 0;
        end else begin
            check("mon_in_ready", {31'd0, in_ready}, {31'd0, (in_s ? mx != DEPTH : my != DEPTH)});
            check("mon_x_valid", {31'd0, x_valid}, {31'd0, mx != 0});
            check("mon_y_valid", {31'd0, y_valid}, {31'd0, my != 0});
            check("mon_x_count", 32'(x_count), 32'(mx));
            check("mon_y_count", 32'(y_count), 32'(my));
            check("mon_x_data", 32'(x_data), (mx != 0) ? 32'(xq[0]) : 32'd0);
            check("mon_y_data", 32'(y_data), (my != 0) ? 32'(yq[0]) : 32'd0);
`ifdef DEMUX_STATS_EN
            check("mon_x_beats", 32'(x_beats), 32'(xb));
            check("mon_y_beats", 32'(y_beats), 32'(yb));
`endif
            xpop  = (mx != 0) && x_ready;
            ypop  = (my != 0) && y_ready;
            xpush = in_valid && in_s && (mx != DEPTH);
            ypush = in_valid && !in_s && (my != DEPTH);
            if (xpop) void'(xq.pop_front());
            if (ypop) void'(yq.pop_front());
            if (xpush) xq.push_back(in_data);
            if (ypush) yq.push_back(in_data);
            mx = mx + int'(xpush) - int'(xpop);
            my = my + int'(ypush) - int'(ypop);
            if (xpop && xb != 16'hFFFF) xb++;
            if (ypop && yb != 16'hFFFF) yb++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted, with random consumer readiness.
    task automatic send_random(input logic s, input logic [N-1:0] d);
        int t;
        in_valid = 1'b1;
        in_s     = s;
        in_data  = d;
        t = 0;
        while (t < 200) begin
            x_ready = 1'($urandom_range(0, 1));
            y_ready = 1'($urandom_range(0, 1));
            if (in_ready) begin
                step();
                break;
            end
            step();
            t++;
        end
        if (t >= 200) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xb_base, yb_base;
        rst_n    = 1'b0;
        in_data  = '0;
        in_s     = 1'b0;
        in_valid = 1'b0;
        x_ready  = 1'b0;
        y_ready  = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_x_valid", {31'd0, x_valid}, 32'd0);
        check("rst_y_valid", {31'd0, y_valid}, 32'd0);
        check("rst_x_data", 32'(x_data), 32'd0);
        check("rst_y_data", 32'(y_data), 32'd0);
        check("rst_x_count", 32'(x_count), 32'd0);
        check("rst_y_count", 32'(y_count), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // Basic routing, one-cycle latency
        x_ready = 1'b1; y_ready = 1'b1;
        in_valid = 1'b1; in_s = 1'b1; in_data = 4'hA;
        step();
        check("lat_x_valid", {31'd0, x_valid}, 32'd1);
        check("lat_x_data", 32'(x_data), 32'hA);
        in_s = 1'b0; in_data = 4'h5;
        step();
        check("lat_y_valid", {31'd0, y_valid}, 32'd1);
        check("lat_y_data", 32'(y_data), 32'h5);
        in_valid = 1'b0;
        step();
        check("basic_x_count", 32'(x_count), 32'd0);
        check("basic_y_count", 32'(y_count), 32'd0);

        // Fill x, bypass to y, pop-while-full rejection
        x_ready = 1'b0; y_ready = 1'b1;
        in_valid = 1'b1; in_s = 1'b1; in_data = 4'h1;
        step();
        in_data = 4'h2;
        step();
        in_data = 4'h3;
        #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_x_count", 32'(x_count), 32'd2);
        step();
        check("full_hold_count", 32'(x_count), 32'd2);
        in_s = 1'b0; in_data = 4'h7;
        #1;
        check("bypass_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bypass_y_data", 32'(y_data), 32'h7);
        in_s = 1'b1; in_data = 4'h3; x_ready = 1'b1;
        #1;
        check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("pop_only_count", 32'(x_count), 32'd1);
        check("pop_only_head", 32'(x_data), 32'h2);
        step();
        check("push_pop_count", 32'(x_count), 32'd1);
        check("push_pop_head", 32'(x_data), 32'h3);
        in_valid = 1'b0;
        step();
        check("drain_x_count", 32'(x_count), 32'd0);
        step();

        // Alternating traffic with random backpressure
        xb_base = xb; yb_base = yb;
        for (int i = 0; i < 10; i++)
            send_random((i % 2) == 0, 4'($urandom_range(0, 15)));
        x_ready = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("alt_x_empty", 32'(x_count), 32'd0);
        check("alt_y_empty", 32'(y_count), 32'd0);
`ifdef DEMUX_STATS_EN
        check("alt_x_beats", 32'(x_beats) - 32'(xb_base), 32'd5);
        check("alt_y_beats", 32'(y_beats) - 32'(yb_base), 32'd5);
`endif

        // Asynchronous reset with both FIFOs holding two beats
        x_ready = 1'b0; y_ready = 1'b0;
        in_valid = 1'b1;
        in_s = 1'b1; in_data = 4'h4; step();
        in_s = 1'b0; in_data = 4'h6; step();
        in_s = 1'b1; in_data = 4'h8; step();
        in_s = 1'b0; in_data = 4'h9; step();
        in_valid = 1'b0;
        check("pre_rst_x_count", 32'(x_count), 32'd2);
        check("pre_rst_y_count", 32'(y_count), 32'd2);
        #2;
        rst_n = 1'b0;
        x_ready = 1'b1; y_ready = 1'b1;
        #1;
        check("arst_x_valid", {31'd0, x_valid}, 32'd0);
        check("arst_y_valid", {31'd0, y_valid}, 32'd0);
        check("arst_x_count", 32'(x_count), 32'd0);
        check("arst_y_count", 32'(y_count), 32'd0);
        check("arst_x_data", 32'(x_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_s = 1'b1; in_data = 4'hC; x_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("post_rst_x_valid", {31'd0, x_valid}, 32'd1);
        check("post_rst_x_data", 32'(x_data), 32'hC);
        check("post_rst_x_count", 32'(x_count), 32'd1);
        x_ready = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
